// File: rtl/fifo_write_arbiter.sv
// fifo_write_arbiter
//   Round-robin arbiter that lets one of NUM_REQ requesters at a time write
//   words into a shared FIFO. A grant lasts until the owner drops its valid
//   or, with bursts enabled, until BURST_LEN words have been accepted.
//   FIFO back-pressure stalls the owner without ending its grant.
//
//   Optional feature macro: FIFO_ARB_BURST_EN
//     defined   : a grant carries up to BURST_LEN words
//     undefined : a grant ends after every accepted word; no burst counter
//
// Ports
//   clk        : clock, rising edge
//   reset      : asynchronous reset, active low
//   req_valid  : requester i holds a word
//   req_data   : requester i word at [i*DATA_BITS +: DATA_BITS]
//   req_ready  : word of requester i accepted this cycle (with req_valid[i])
//   fifo_write : FIFO write strobe
//   fifo_data  : FIFO write data (0 when not writing)
//   fifo_full  : FIFO full flag
//   grant_id   : current owner while granted, else 0
//   busy       : high while a grant is active
module fifo_write_arbiter #(
  parameter int NUM_REQ   = 4,
  parameter int DATA_BITS = 8,
  parameter int BURST_LEN = 4
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic [NUM_REQ-1:0]           req_valid,
  input  logic [NUM_REQ*DATA_BITS-1:0] req_data,
  output logic [NUM_REQ-1:0]           req_ready,
  output logic                         fifo_write,
  output logic [DATA_BITS-1:0]         fifo_data,
  input  logic                         fifo_full,
  output logic [$clog2(NUM_REQ)-1:0]   grant_id,
  output logic                         busy
);

  localparam int ID_W = $clog2(NUM_REQ);
  localparam logic [ID_W-1:0] LAST_IDX = ID_W'(NUM_REQ - 1);

  typedef enum logic {IDLE = 1'b0, GRANT = 1'b1} state_t;

  state_t              state, state_nxt;
  logic [ID_W-1:0]     owner, owner_nxt;
  logic [ID_W-1:0]     last_owner, last_owner_nxt;
  logic [ID_W-1:0]     rr_base, rr_pick;
  logic [DATA_BITS-1:0] words [NUM_REQ];
  logic                owner_valid, accept, burst_done, release_grant, any_valid;

  for (genvar g = 0; g < NUM_REQ; g++) begin : g_unpack
    assign words[g] = req_data[g*DATA_BITS +: DATA_BITS];
  end

  // First valid requester after 'base', wrapping; 'base' itself is searched
  // last, so a just-released owner only wins when nobody else is waiting.
  function automatic logic [ID_W-1:0] rr_next(input logic [NUM_REQ-1:0] valid,
                                              input logic [ID_W-1:0]    base);
    logic [ID_W-1:0] pick;
    logic            found;
    int              idx;
    pick  = '0;
    found = 1'b0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      idx = (int'(base) + k) % NUM_REQ;
      if (!found && valid[ID_W'(idx)]) begin
        pick  = ID_W'(idx);
        found = 1'b1;
      end
    end
    return pick;
  endfunction

  assign any_valid   = |req_valid;
  assign owner_valid = req_valid[owner];
  assign accept      = (state == GRANT) && owner_valid && !fifo_full;
  assign rr_base     = (state == GRANT) ? owner : last_owner;
  assign rr_pick     = rr_next(req_valid, rr_base);

`ifdef FIFO_ARB_BURST_EN
  localparam logic [7:0] BURST_MAX = 8'(BURST_LEN);

  logic [7:0] burst_cnt, burst_cnt_nxt;

  function automatic logic [7:0] sat_inc(input logic [7:0] cnt);
    return (cnt >= BURST_MAX) ? BURST_MAX : cnt + 8'd1;
  endfunction

  assign burst_done = accept && (sat_inc(burst_cnt) == BURST_MAX);
`else
  assign burst_done = accept;
`endif

  // A stalled owner (valid but FIFO full) neither accepts nor releases.
  assign release_grant = burst_done || !owner_valid;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= IDLE;
      owner      <= '0;
      last_owner <= LAST_IDX;
`ifdef FIFO_ARB_BURST_EN
      burst_cnt  <= '0;
`endif
    end else begin
      state      <= state_nxt;
      owner      <= owner_nxt;
      last_owner <= last_owner_nxt;
`ifdef FIFO_ARB_BURST_EN
      burst_cnt  <= burst_cnt_nxt;
`endif
    end
  end

  always_comb begin
    state_nxt      = state;
    owner_nxt      = owner;
    last_owner_nxt = last_owner;
`ifdef FIFO_ARB_BURST_EN
    burst_cnt_nxt  = burst_cnt;
`endif
    case (state)
      IDLE: begin
        if (any_valid) begin
          state_nxt     = GRANT;
          owner_nxt     = rr_pick;
`ifdef FIFO_ARB_BURST_EN
          burst_cnt_nxt = '0;
`endif
        end
      end
      GRANT: begin
        if (release_grant) begin
          last_owner_nxt = owner;
`ifdef FIFO_ARB_BURST_EN
          burst_cnt_nxt  = '0;
`endif
          // Hand over directly to the next requester, no idle cycle.
          if (any_valid) owner_nxt = rr_pick;
          else           state_nxt = IDLE;
        end
`ifdef FIFO_ARB_BURST_EN
        else if (accept) begin
          burst_cnt_nxt = sat_inc(burst_cnt);
        end
`endif
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    req_ready  = '0;
    fifo_write = 1'b0;
    fifo_data  = '0;
    grant_id   = '0;
    busy       = 1'b0;
    if (state == GRANT) begin
      req_ready[owner] = !fifo_full;
      fifo_write       = accept;
      fifo_data        = accept ? words[owner] : '0;
      grant_id         = owner;
      busy             = 1'b1;
    end
  end

endmodule

// File: tb/tb_fifo_write_arbiter.sv
// Testbench for fifo_write_arbiter (NUM_REQ=4, DATA_BITS=5, BURST_LEN=4).
// Works with or without FIFO_ARB_BURST_EN; the reference model follows the
// same macro to pick the effective burst length.
module tb_fifo_write_arbiter;

  localparam int N   = 4;
  localparam int DW  = 5;
  localparam int BL  = 4;
  localparam int IW  = $clog2(N);
  localparam int RDW = N * DW;
`ifdef FIFO_ARB_BURST_EN
  localparam int EFF = BL;
`else
  localparam int EFF = 1;
`endif

  logic           clk = 1'b0;
  logic           reset = 1'b0;
  logic [N-1:0]   req_valid = '0;
  logic [RDW-1:0] req_data = '0;
  logic           fifo_full = 1'b0;
  logic [N-1:0]   req_ready;
  logic           fifo_write;
  logic [DW-1:0]  fifo_data;
  logic [IW-1:0]  grant_id;
  logic           busy;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  fifo_write_arbiter #(.NUM_REQ(N), .DATA_BITS(DW), .BURST_LEN(BL)) dut (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_data(req_data),
    .req_ready(req_ready), .fifo_write(fifo_write), .fifo_data(fifo_data),
    .fifo_full(fifo_full), .grant_id(grant_id), .busy(busy)
  );

  // Reference model: who owns the FIFO, who owned it last, words so far.
  bit            m_busy;
  int            m_owner, m_last, m_cnt;
  logic [N-1:0]  e_ready;
  logic          e_write;
  logic [DW-1:0] e_data;
  logic [IW-1:0] e_gid;
  logic          e_busy;

  task automatic model_reset();
    m_busy = 0; m_owner = 0; m_last = N - 1; m_cnt = 0;
  endtask

  function automatic int rr_pick(input int base);
    for (int k = 1; k <= N; k++)
      if (req_valid[(base + k) % N]) return (base + k) % N;
    return base;
  endfunction

  task automatic model_eval();
    e_busy  = m_busy;
    e_gid   = m_busy ? IW'(m_owner) : '0;
    e_write = m_busy && req_valid[m_owner] && !fifo_full;
    e_ready = '0;
    if (m_busy && !fifo_full) e_ready[m_owner] = 1'b1;
    e_data  = e_write ? req_data[m_owner*DW +: DW] : '0;
  endtask

  task automatic model_advance();
    if (!m_busy) begin
      if (req_valid != '0) begin
        m_owner = rr_pick(m_last); m_busy = 1; m_cnt = 0;
      end
    end else begin
      if (e_write) m_cnt++;
      if ((e_write && m_cnt == EFF) || !req_valid[m_owner]) begin
        m_last = m_owner; m_cnt = 0;
        if (req_valid != '0) m_owner = rr_pick(m_last);
        else                 m_busy = 0;
      end
    end
  endtask

  task automatic set_word(input int i, input int w);
    req_data[i*DW +: DW] = DW'(w);
  endtask

  task automatic settle();
    #1;
    model_eval();
  endtask

  task automatic advance();
    model_advance();
    @(negedge clk);
  endtask

  task automatic do_reset();
    reset = 1'b0; req_valid = '0; fifo_full = 1'b0; req_data = '0;
    @(negedge clk);
    reset = 1'b1;
    model_reset();
  endtask

  task automatic test_reset();
    for (int c = 0; c < 4; c++) begin
      req_valid = N'($urandom);
      fifo_full = ($urandom % 2) == 1;
      req_data  = RDW'($urandom);
      #1;
      n_tests++;
      if ({req_ready, fifo_write, fifo_data, grant_id, busy} !== '0) begin
        n_fail++;
        $display("FAIL reset_outs c=%0d: got %h want 0", c,
                 {req_ready, fifo_write, fifo_data, grant_id, busy});
      end
      @(negedge clk);
    end
    req_valid = '1; fifo_full = 1'b0;
    for (int i = 0; i < N; i++) set_word(i, i + 1);
    reset = 1'b1;
    model_reset();
    settle();
    n_tests++;
    if ({req_ready, fifo_write, fifo_data, grant_id, busy} !==
        {e_ready, e_write, e_data, e_gid, e_busy}) begin
      n_fail++;
      $display("FAIL reset_idle: got %h want %h",
               {req_ready, fifo_write, fifo_data, grant_id, busy},
               {e_ready, e_write, e_data, e_gid, e_busy});
    end
    advance();
    settle();
    n_tests++;
    if (grant_id !== 0 || busy !== 1'b1 || fifo_write !== 1'b1 || fifo_data !== DW'(1)) begin
      n_fail++;
      $display("FAIL first_grant: got id=%0d busy=%b wr=%b data=%0d want id=0 busy=1 wr=1 data=1",
               grant_id, busy, fifo_write, fifo_data);
    end
    // Asynchronous assertion while granted, away from any clock edge.
    #2 reset = 1'b0;
    #1;
    n_tests++;
    if ({req_ready, fifo_write, fifo_data, grant_id, busy} !== '0) begin
      n_fail++;
      $display("FAIL reset_async: got %h want 0",
               {req_ready, fifo_write, fifo_data, grant_id, busy});
    end
    model_reset();
    @(negedge clk);
  endtask

  task automatic test_single();
    int vals[3] = '{3, 6, 9};
    int idx = 0;
    bit exp_w, exp_b;
    do_reset();
    for (int c = 0; c < 7; c++) begin
      req_valid = (idx < 3) ? 4'b0100 : 4'b0000;
      set_word(2, (idx < 3) ? vals[idx] : 0);
      settle();
      n_tests++;
      if ({req_ready, fifo_write, fifo_data, grant_id, busy} !==
          {e_ready, e_write, e_data, e_gid, e_busy}) begin
        n_fail++;
        $display("FAIL single_model c=%0d: got %h want %h", c,
                 {req_ready, fifo_write, fifo_data, grant_id, busy},
                 {e_ready, e_write, e_data, e_gid, e_busy});
      end
      exp_w = (c >= 1 && c <= 3);
      exp_b = (c >= 1 && c <= 4);
      n_tests++;
      if (fifo_write !== exp_w || busy !== exp_b || (exp_b && grant_id !== 2)) begin
        n_fail++;
        $display("FAIL single_seq c=%0d: got wr=%b busy=%b id=%0d want wr=%b busy=%b id=2",
                 c, fifo_write, busy, grant_id, exp_w, exp_b);
      end
      if (exp_w) begin
        n_tests++;
        if (fifo_data !== DW'(vals[c-1])) begin
          n_fail++;
          $display("FAIL single_data c=%0d: got %0d want %0d", c, fifo_data, vals[c-1]);
        end
      end
      if (e_write) idx++;
      advance();
    end
  endtask

  task automatic test_burst_rotation();
    int seq[N] = '{0, 0, 0, 0};
    int exp_g;
    do_reset();
    req_valid = '1;
    for (int c = 0; c < 18; c++) begin
      for (int i = 0; i < N; i++) set_word(i, i * 8 + seq[i]);
      settle();
      n_tests++;
      if ({req_ready, fifo_write, fifo_data, grant_id, busy} !==
          {e_ready, e_write, e_data, e_gid, e_busy}) begin
        n_fail++;
        $display("FAIL rot_model c=%0d: got %h want %h", c,
                 {req_ready, fifo_write, fifo_data, grant_id, busy},
                 {e_ready, e_write, e_data, e_gid, e_busy});
      end
      if (c >= 1) begin
        exp_g = ((c - 1) / EFF) % N;
        n_tests++;
        if (fifo_write !== 1'b1 || grant_id !== IW'(exp_g)) begin
          n_fail++;
          $display("FAIL rot_owner c=%0d: got wr=%b id=%0d want wr=1 id=%0d",
                   c, fifo_write, grant_id, exp_g);
        end
      end
      for (int i = 0; i < N; i++) if (e_ready[i]) seq[i]++;
      advance();
    end
  endtask

  task automatic test_stall();
    int idx = 0;
    int nw = 0;
    bit exp_w;
    do_reset();
    for (int c = 0; c < 10; c++) begin
      req_valid = (idx < 4) ? 4'b0010 : 4'b0000;
      set_word(1, 10 + idx);
      fifo_full = (c >= 3 && c <= 5);
      settle();
      n_tests++;
      if ({req_ready, fifo_write, fifo_data, grant_id, busy} !==
          {e_ready, e_write, e_data, e_gid, e_busy}) begin
        n_fail++;
        $display("FAIL stall_model c=%0d: got %h want %h", c,
                 {req_ready, fifo_write, fifo_data, grant_id, busy},
                 {e_ready, e_write, e_data, e_gid, e_busy});
      end
      exp_w = (c == 1 || c == 2 || c == 6 || c == 7);
      n_tests++;
      if (fifo_write !== exp_w || (exp_w && fifo_data !== DW'(10 + nw))) begin
        n_fail++;
        $display("FAIL stall_write c=%0d: got wr=%b data=%0d want wr=%b data=%0d",
                 c, fifo_write, fifo_data, exp_w, 10 + nw);
      end
      if (c >= 3 && c <= 5) begin
        n_tests++;
        if (req_ready !== '0 || grant_id !== 1 || busy !== 1'b1) begin
          n_fail++;
          $display("FAIL stall_hold c=%0d: got ready=%b id=%0d busy=%b want ready=0 id=1 busy=1",
                   c, req_ready, grant_id, busy);
        end
      end
      if (fifo_write === 1'b1) nw++;
      if (e_write) idx++;
      advance();
    end
    fifo_full = 1'b0;
    n_tests++;
    if (nw !== 4) begin
      n_fail++;
      $display("FAIL stall_count: got %0d writes want 4", nw);
    end
  endtask

  task automatic test_reset_midburst();
    int idx = 0;
    do_reset();
    for (int c = 0; c < 4; c++) begin
      req_valid = 4'b1000;
      set_word(3, 20 + idx);
      settle();
      n_tests++;
      if ({req_ready, fifo_write, fifo_data, grant_id, busy} !==
          {e_ready, e_write, e_data, e_gid, e_busy}) begin
        n_fail++;
        $display("FAIL midrst_model c=%0d: got %h want %h", c,
                 {req_ready, fifo_write, fifo_data, grant_id, busy},
                 {e_ready, e_write, e_data, e_gid, e_busy});
      end
      if (c < 3) begin
        if (e_write) idx++;
        advance();
      end
    end
    #2 reset = 1'b0;
    #1;
    n_tests++;
    if (fifo_write !== 1'b0 || busy !== 1'b0 || req_ready !== '0 || fifo_data !== '0) begin
      n_fail++;
      $display("FAIL midrst_drop: got wr=%b busy=%b ready=%b data=%0d want all 0",
               fifo_write, busy, req_ready, fifo_data);
    end
    model_reset();
    @(negedge clk);
    req_valid = '1;
    for (int i = 0; i < N; i++) set_word(i, i + 5);
    reset = 1'b1;
    settle();
    advance();
    settle();
    n_tests++;
    if (grant_id !== 0 || busy !== 1'b1) begin
      n_fail++;
      $display("FAIL midrst_regrant: got id=%0d busy=%b want id=0 busy=1", grant_id, busy);
    end
    advance();
  endtask

  task automatic test_random();
    int seq[N] = '{0, 0, 0, 0};
    bit acc[N];
    int seen = 0;
    int expd = 0;
    do_reset();
    for (int i = 0; i < N; i++) acc[i] = 0;
    for (int c = 0; c < 1500; c++) begin
      for (int i = 0; i < N; i++) begin
        if (acc[i])            req_valid[i] = ($urandom % 4) != 0;
        else if (!req_valid[i]) req_valid[i] = ($urandom % 3) == 0;
        set_word(i, i * 8 + seq[i]);
      end
      fifo_full = ($urandom % 4) == 0;
      settle();
      n_tests++;
      if ({req_ready, fifo_write, fifo_data, grant_id, busy} !==
          {e_ready, e_write, e_data, e_gid, e_busy}) begin
        n_fail++;
        $display("FAIL rand_model c=%0d: got %h want %h", c,
                 {req_ready, fifo_write, fifo_data, grant_id, busy},
                 {e_ready, e_write, e_data, e_gid, e_busy});
      end
      if (fifo_write === 1'b1) seen++;
      if (e_write) expd++;
      for (int i = 0; i < N; i++) begin
        acc[i] = e_ready[i] && req_valid[i];
        if (acc[i]) seq[i]++;
      end
      advance();
    end
    n_tests++;
    if (seen !== expd) begin
      n_fail++;
      $display("FAIL rand_count: got %0d writes want %0d", seen, expd);
    end
  endtask

  initial begin
    model_reset();
    @(negedge clk);
    test_reset();
    test_single();
    test_burst_rotation();
    test_stall();
    test_reset_midburst();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
